// File: rtl/ap_ctrl_txn_recorder.sv
// Records ap_ctrl_hs transactions on a monitored kernel: timestamps start and done,
// pairs them in order and streams {id, start, done, latency} records to a trace sink.
module ap_ctrl_txn_recorder #(
  parameter int TS_W    = 32,
  parameter int MAX_OUT = 4,
  parameter int DEPTH   = 8,
  parameter int ID_W    = 16
) (
  input  logic            ap_clk,
  input  logic            ap_rst_n,
  input  logic            enable,
  input  logic            mon_ap_start,
  input  logic            mon_ap_ready,
  input  logic            mon_ap_done,
  input  logic            mon_ap_continue,
  output logic            rec_valid,
  input  logic            rec_ready,
  output logic [ID_W-1:0] rec_id,
  output logic [TS_W-1:0] rec_start_ts,
  output logic [TS_W-1:0] rec_done_ts,
  output logic [TS_W-1:0] rec_latency,
  output logic [15:0]     drop_cnt,
  output logic            orphan_done,
  output logic            busy
);

  localparam int SQ_AW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int RF_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {IDLE, RUN} state_e;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [TS_W-1:0] start_ts;
    logic [TS_W-1:0] done_ts;
  } rec_t;

  state_e          state_q;
  logic [TS_W-1:0] ts_q;
  logic [ID_W-1:0] id_q;
  logic [15:0]     drop_q;
  logic            orphan_q;

  logic [TS_W-1:0] sq_mem [MAX_OUT];
  logic [SQ_AW-1:0] sq_wr_q, sq_rd_q;
  logic [SQ_AW:0]   sq_cnt_q;

  rec_t            rf_mem [DEPTH];
  logic [RF_AW-1:0] rf_wr_q, rf_rd_q;
  logic [RF_AW:0]   rf_cnt_q;

  logic start_fire, done_fire, bypass;
  logic sq_empty, sq_full, sq_push, sq_pop, start_drop;
  logic rec_push, rf_full, rf_push, rf_pop, rec_drop, orphan_evt;
  logic [16:0] drop_sum;
  rec_t rec_new, rec_head;

  // Start events are only recognised on the IDLE->start edge of the handshake.
  assign start_fire = enable && (state_q == IDLE) && mon_ap_start;
  assign done_fire  = enable && mon_ap_done && mon_ap_continue;

  assign sq_empty   = (sq_cnt_q == '0);
  assign sq_full    = (sq_cnt_q == (SQ_AW+1)'(MAX_OUT));
  assign bypass     = done_fire && sq_empty && start_fire;
  assign sq_pop     = done_fire && !sq_empty;
  assign sq_push    = start_fire && !bypass && (!sq_full || sq_pop);
  assign start_drop = start_fire && !bypass && sq_full && !sq_pop;
  assign orphan_evt = done_fire && sq_empty && !start_fire;

  assign rec_push = sq_pop || bypass;
  assign rec_new  = '{id: id_q, start_ts: (sq_pop ? sq_mem[sq_rd_q] : ts_q), done_ts: ts_q};

  assign rec_valid = (rf_cnt_q != '0);
  assign rf_full   = (rf_cnt_q == (RF_AW+1)'(DEPTH));
  assign rf_pop    = rec_valid && rec_ready;
  assign rf_push   = rec_push && (!rf_full || rf_pop);
  assign rec_drop  = rec_push && !rf_push;

  assign drop_sum = {1'b0, drop_q} + 17'(start_drop) + 17'(rec_drop);

  // Data is gated by rec_valid so the unreset storage never shows at the port.
  assign rec_head     = rf_mem[rf_rd_q];
  assign rec_id       = rec_valid ? rec_head.id : '0;
  assign rec_start_ts = rec_valid ? rec_head.start_ts : '0;
  assign rec_done_ts  = rec_valid ? rec_head.done_ts : '0;
  assign rec_latency  = rec_valid ? (rec_head.done_ts - rec_head.start_ts) : '0;

  assign drop_cnt    = drop_q;
  assign orphan_done = orphan_q;
  assign busy        = !sq_empty;

  // NOTE: storage arrays carry no reset; validity lives entirely in the reset counters.
  always_ff @(posedge ap_clk) begin
    if (sq_push) sq_mem[sq_wr_q] <= ts_q;
    if (rf_push) rf_mem[rf_wr_q] <= rec_new;
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q  <= IDLE;
      ts_q     <= '0;
      id_q     <= '0;
      drop_q   <= '0;
      orphan_q <= 1'b0;
      sq_wr_q  <= '0;
      sq_rd_q  <= '0;
      sq_cnt_q <= '0;
      rf_wr_q  <= '0;
      rf_rd_q  <= '0;
      rf_cnt_q <= '0;
    end else begin
      if (enable) ts_q <= ts_q + 1'b1;

      if (!enable) begin
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE:    if (mon_ap_start && !mon_ap_ready) state_q <= RUN;
          RUN:     if (mon_ap_ready) state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end

      if (sq_push) sq_wr_q <= (sq_wr_q == SQ_AW'(MAX_OUT-1)) ? '0 : sq_wr_q + 1'b1;
      if (sq_pop)  sq_rd_q <= (sq_rd_q == SQ_AW'(MAX_OUT-1)) ? '0 : sq_rd_q + 1'b1;
      sq_cnt_q <= sq_cnt_q + (SQ_AW+1)'(sq_push) - (SQ_AW+1)'(sq_pop);

      if (rf_push) rf_wr_q <= (rf_wr_q == RF_AW'(DEPTH-1)) ? '0 : rf_wr_q + 1'b1;
      if (rf_pop)  rf_rd_q <= (rf_rd_q == RF_AW'(DEPTH-1)) ? '0 : rf_rd_q + 1'b1;
      rf_cnt_q <= rf_cnt_q + (RF_AW+1)'(rf_push) - (RF_AW+1)'(rf_pop);

      // The id advances for every formed record, including ones lost to a full FIFO.
      if (rec_push)   id_q     <= id_q + 1'b1;
      if (orphan_evt) orphan_q <= 1'b1;
      drop_q <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end

endmodule

// File: tb/tb_ap_ctrl_txn_recorder.sv
// Scoreboard bench for ap_ctrl_txn_recorder: directed handshakes push expected records,
// monitors pop and compare whenever a record is accepted by the sink.
module tb_ap_ctrl_txn_recorder;

  typedef struct {
    logic [31:0] id;
    logic [31:0] st;
    logic [31:0] dn;
    logic [31:0] lat;
    int          pop_ts;
  } exp_t;

  logic clk = 1'b0;
  logic ap_rst_n, enable;
  logic mon_ap_start, mon_ap_ready, mon_ap_done, mon_ap_continue;
  logic rec_valid, rec_ready;
  logic [15:0] rec_id;
  logic [31:0] rec_start_ts, rec_done_ts, rec_latency;
  logic [15:0] drop_cnt;
  logic orphan_done, busy;

  logic n_start, n_ready, n_done;
  logic n_rec_valid;
  logic [15:0] n_rec_id;
  logic [3:0]  n_rec_start_ts, n_rec_done_ts, n_rec_latency;
  logic [15:0] n_drop_cnt;
  logic n_orphan_done, n_busy;

  int checks = 0;
  int errors = 0;
  int tb_ts;
  exp_t exp_q[$];
  exp_t n_exp_q[$];
  exp_t mon_e, n_mon_e;

  always #5 clk = ~clk;

  ap_ctrl_txn_recorder u_dut (
    .ap_clk(clk), .ap_rst_n(ap_rst_n), .enable(enable),
    .mon_ap_start(mon_ap_start), .mon_ap_ready(mon_ap_ready),
    .mon_ap_done(mon_ap_done), .mon_ap_continue(mon_ap_continue),
    .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_id(rec_id),
    .rec_start_ts(rec_start_ts), .rec_done_ts(rec_done_ts), .rec_latency(rec_latency),
    .drop_cnt(drop_cnt), .orphan_done(orphan_done), .busy(busy)
  );

  ap_ctrl_txn_recorder #(.TS_W(4)) u_dut4 (
    .ap_clk(clk), .ap_rst_n(ap_rst_n), .enable(enable),
    .mon_ap_start(n_start), .mon_ap_ready(n_ready),
    .mon_ap_done(n_done), .mon_ap_continue(1'b1),
    .rec_valid(n_rec_valid), .rec_ready(1'b1), .rec_id(n_rec_id),
    .rec_start_ts(n_rec_start_ts), .rec_done_ts(n_rec_done_ts), .rec_latency(n_rec_latency),
    .drop_cnt(n_drop_cnt), .orphan_done(n_orphan_done), .busy(n_busy)
  );

  // Cycle index since reset release, advancing only while enabled.
  always @(posedge clk or negedge ap_rst_n) begin
    if (!ap_rst_n) tb_ts <= 0;
    else if (enable) tb_ts <= tb_ts + 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (ap_rst_n && rec_valid && rec_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_record: got id %0d expected none", rec_id);
      end else begin
        mon_e = exp_q.pop_front();
        check("rec_id", 64'(rec_id), 64'(mon_e.id));
        check("rec_start_ts", 64'(rec_start_ts), 64'(mon_e.st));
        check("rec_done_ts", 64'(rec_done_ts), 64'(mon_e.dn));
        check("rec_latency", 64'(rec_latency), 64'(mon_e.lat));
        check("rec_pop_ts", 64'(tb_ts), 64'(mon_e.pop_ts));
      end
    end
  end

  always @(negedge clk) begin
    if (ap_rst_n && n_rec_valid) begin
      if (n_exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_narrow_record: got id %0d expected none", n_rec_id);
      end else begin
        n_mon_e = n_exp_q.pop_front();
        check("n_rec_id", 64'(n_rec_id), 64'(n_mon_e.id));
        check("n_rec_start_ts", 64'(n_rec_start_ts), 64'(n_mon_e.st));
        check("n_rec_done_ts", 64'(n_rec_done_ts), 64'(n_mon_e.dn));
        check("n_rec_latency", 64'(n_rec_latency), 64'(n_mon_e.lat));
        check("n_rec_pop_ts", 64'(tb_ts), 64'(n_mon_e.pop_ts));
      end
    end
  end

  task automatic at_ts(input int n);
    while (tb_ts < n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic push_exp(input int id, input int st, input int dn, input int lat, input int pts);
    exp_t e;
    e.id = 32'(id); e.st = 32'(st); e.dn = 32'(dn); e.lat = 32'(lat); e.pop_ts = pts;
    exp_q.push_back(e);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_rec_valid"}, 64'(rec_valid), 64'd0);
    check({tag, "_rec_data"}, {rec_id, rec_start_ts[15:0], rec_done_ts[15:0], rec_latency[15:0]}, 64'd0);
    check({tag, "_drop_cnt"}, 64'(drop_cnt), 64'd0);
    check({tag, "_orphan_busy"}, {62'd0, orphan_done, busy}, 64'd0);
  endtask

  task automatic do_reset();
    ap_rst_n = 1'b0;
    enable = 1'b0;
    {mon_ap_start, mon_ap_ready, mon_ap_done} = 3'b000;
    {n_start, n_ready, n_done} = 3'b000;
    rec_ready = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check_zero_outputs("reset");
    @(negedge clk);
    ap_rst_n = 1'b1;
    enable = 1'b1;
  endtask

  initial begin
    mon_ap_continue = 1'b1;

    // Basic transaction: start 5, ready 7, done 12.
    do_reset();
    rec_ready = 1'b1;
    push_exp(0, 5, 12, 7, 13);
    at_ts(5);  mon_ap_start = 1'b1;
    at_ts(7);  mon_ap_ready = 1'b1;
    at_ts(8);  mon_ap_start = 1'b0; mon_ap_ready = 1'b0;
    at_ts(12); check("t1_valid_before_done", 64'(rec_valid), 64'd0); mon_ap_done = 1'b1;
    at_ts(13); mon_ap_done = 1'b0;
    at_ts(14); check("t1_valid_one_cycle", 64'(rec_valid), 64'd0);
    check("t1_drained", 64'(exp_q.size()), 64'd0);

    // Start queue overflow: five starts, one dropped, then four dones.
    do_reset();
    rec_ready = 1'b1;
    for (int i = 0; i < 4; i++) push_exp(i, i, 10 + i, 10, 11 + i);
    at_ts(0); mon_ap_start = 1'b1; mon_ap_ready = 1'b1;
    at_ts(5); mon_ap_start = 1'b0; mon_ap_ready = 1'b0;
    at_ts(6);
    check("t2_busy", 64'(busy), 64'd1);
    check("t2_drop_cnt", 64'(drop_cnt), 64'd1);
    at_ts(10); mon_ap_done = 1'b1;
    at_ts(14); mon_ap_done = 1'b0;
    at_ts(16);
    check("t2_busy_clear", 64'(busy), 64'd0);
    check("t2_drained", 64'(exp_q.size()), 64'd0);

    // Record FIFO overflow with a stalled sink.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      at_ts(2 * i);     mon_ap_start = 1'b1; mon_ap_ready = 1'b1;
      at_ts(2 * i + 1); mon_ap_start = 1'b0; mon_ap_ready = 1'b0; mon_ap_done = 1'b1;
      at_ts(2 * i + 2); mon_ap_done = 1'b0;
    end
    check("t3_drop_cnt", 64'(drop_cnt), 64'd1);
    check("t3_head_18", {rec_id, rec_start_ts[15:0], rec_done_ts[15:0], rec_latency[15:0]},
          {16'd0, 16'd0, 16'd1, 16'd1});
    at_ts(21);
    check("t3_head_stable_21", {rec_id, rec_start_ts[15:0], rec_done_ts[15:0], rec_latency[15:0]},
          {16'd0, 16'd0, 16'd1, 16'd1});
    check("t3_valid_stalled", 64'(rec_valid), 64'd1);
    for (int i = 0; i < 8; i++) push_exp(i, 2 * i, 2 * i + 1, 1, 22 + i);
    at_ts(22); rec_ready = 1'b1;
    at_ts(32);
    check("t3_empty_after", 64'(rec_valid), 64'd0);
    check("t3_drained", 64'(exp_q.size()), 64'd0);

    // Start, ready and done in a single cycle with an empty queue.
    do_reset();
    rec_ready = 1'b1;
    push_exp(0, 20, 20, 0, 21);
    at_ts(20); mon_ap_start = 1'b1; mon_ap_ready = 1'b1; mon_ap_done = 1'b1;
    at_ts(21); mon_ap_start = 1'b0; mon_ap_ready = 1'b0; mon_ap_done = 1'b0;
    at_ts(22);
    check("t4_busy", 64'(busy), 64'd0);
    check("t4_drained", 64'(exp_q.size()), 64'd0);

    // 4-bit timestamps: start at 14, done at 19 which reads as 3 after wrap.
    do_reset();
    n_exp_q.push_back('{id: 32'd0, st: 32'd14, dn: 32'd3, lat: 32'd5, pop_ts: 20});
    at_ts(14); n_start = 1'b1; n_ready = 1'b1;
    at_ts(15); n_start = 1'b0; n_ready = 1'b0;
    at_ts(19); n_done = 1'b1;
    at_ts(20); n_done = 1'b0;
    at_ts(22);
    check("t5_drained", 64'(n_exp_q.size()), 64'd0);
    check("t5_narrow_busy", 64'(n_busy), 64'd0);

    // Orphan done, then a real transaction, then reset in the middle of RUN.
    do_reset();
    rec_ready = 1'b1;
    at_ts(3); mon_ap_done = 1'b1;
    at_ts(4); mon_ap_done = 1'b0;
    at_ts(5);
    check("t6_orphan", 64'(orphan_done), 64'd1);
    check("t6_no_record", 64'(rec_valid), 64'd0);
    push_exp(0, 6, 9, 3, 10);
    at_ts(6);  mon_ap_start = 1'b1; mon_ap_ready = 1'b1;
    at_ts(7);  mon_ap_start = 1'b0; mon_ap_ready = 1'b0;
    at_ts(9);  mon_ap_done = 1'b1;
    at_ts(10); mon_ap_done = 1'b0;
    at_ts(12);
    check("t6_orphan_sticky", 64'(orphan_done), 64'd1);
    check("t6_drained", 64'(exp_q.size()), 64'd0);
    at_ts(15); mon_ap_start = 1'b1;
    at_ts(16);
    check("t6_busy_run", 64'(busy), 64'd1);
    ap_rst_n = 1'b0;
    #1;
    check_zero_outputs("t6_midrun_reset");
    mon_ap_start = 1'b0;
    enable = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    ap_rst_n = 1'b1;
    enable = 1'b1;
    at_ts(3); mon_ap_done = 1'b1;
    at_ts(4); mon_ap_done = 1'b0;
    at_ts(6);
    check("t6_pending_discarded", 64'(orphan_done), 64'd1);
    check("t6_no_record_after", 64'(rec_valid), 64'd0);
    check("t6_idle_after", 64'(busy), 64'd0);
    check("t6_final_drained", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ap_ctrl_txn_recorder.md
Name: ap_ctrl_txn_recorder

Overview:
- Synthesizable companion to the simulation-only dataflow status monitors.
- Sits on the ap_ctrl_hs control handshake of one kernel or sub-pipeline instance, such as the top CRC24A block or one of its loop pipelines.
- Timestamps each transaction's start and done, pairs them in order, and streams latency records through a valid/ready port to an on-chip trace sink.

Parameters:
TS_W, 32, timestamp and latency width; wraps modulo 2^TS_W
MAX_OUT, 4, depth of the outstanding-start queue (power of 2)
DEPTH, 8, depth of the output record FIFO (power of 2)
ID_W, 16, transaction index width

Ports:
ap_clk  in  1  clock
ap_rst_n  in  1  asynchronous active-low reset
enable  in  1  recording enable
mon_ap_start  in  1  observed ap_start
mon_ap_ready  in  1  observed ap_ready
mon_ap_done  in  1  observed ap_done
mon_ap_continue  in  1  observed ap_continue (tie 1 when absent)
rec_valid  out  1  record available
rec_ready  in  1  sink accepts record
rec_id  out  ID_W  transaction index, from 0
rec_start_ts  out  TS_W  start timestamp
rec_done_ts  out  TS_W  done timestamp
rec_latency  out  TS_W  rec_done_ts - rec_start_ts mod 2^TS_W
drop_cnt  out  16  records lost to full FIFO or full start queue, saturating
orphan_done  out  1  sticky: done seen with no pending start
busy  out  1  start queue non-empty

Behaviour:
- Async reset clears state; while in reset all outputs are 0:
  - ts counter, ID counter, both queues, drop_cnt, orphan_done and the FSM (to IDLE).
  - rec_valid=0; rec_* data=0.
- ts counter increments every cycle while enable=1, holds while enable=0, and wraps silently.
- Events sample the pre-increment ts value of their own cycle.
- Start FSM, states IDLE and RUN:
  - IDLE with start=1: start event fires. If ready=1 in the same cycle, stay in IDLE; otherwise go to RUN.
  - RUN: no start events. Go to IDLE on ready=1.
  - enable=0: FSM forced to IDLE and no events fire.
- Start event:
  - Pushes ts into the start queue.
  - If the queue is full, the event is dropped and drop_cnt increments.
- Done event (done & continue & enable):
  - Pops the oldest start ts, forms a record with id=ID counter, and increments the ID counter (wraps).
  - Start and done in the same cycle with an empty queue: the done pairs with that same-cycle start, latency 0.
  - Done with no start available: no record, orphan_done=1, ID counter unchanged.
- Record FIFO:
  - First-word-fall-through; a record from a done at cycle t is visible with rec_valid=1 at t+1 if the FIFO was empty.
  - Pop on rec_valid & rec_ready.
  - Push with the FIFO full and no pop that cycle: the record is dropped and drop_cnt increments.
  - Push with the FIFO full and a simultaneous pop: both succeed.
  - rec_* data is stable while rec_valid=1 and rec_ready=0.
- drop_cnt saturates at 0xFFFF; two drops in one cycle count as 2.
- The recorder never back-pressures the monitored module. All mon_* inputs are observed only.
- Reset mid-transaction discards pending starts and records. After release the recorder resumes in IDLE, with ts and ID counters at 0.

Test Plan:
1. Reset release, enable=1; start high at ts=5, ready at ts=7, done at ts=12, rec_ready=1 -> one record {id=0, start=5, done=12, latency=7}, rec_valid high for one cycle at ts=13.
2. Five back-to-back starts (start & ready each cycle, ts=0..4) with no done, MAX_OUT=4 -> busy=1, drop_cnt=1. Then four dones at ts=10..13 -> latencies 10,10,10,10, ids 0..3.
3. Hold rec_ready=0 and complete 9 transactions, DEPTH=8 -> 8 records held, drop_cnt=1, ninth record lost. Then raise rec_ready -> ids 0..7 in order, data stable while stalled.
4. Start, ready and done all in one cycle at ts=20 with an empty queue -> record latency 0, start=done=20.
5. TS_W=4; start at ts=14, done at ts=3 after wrap -> latency=5.
6. Done pulse with no prior start -> orphan_done=1, no record, next real transaction gets id=0. Then assert ap_rst_n=0 mid-RUN -> all outputs 0 immediately, no record is produced after release.
